// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the in-flight destination pipe entry.
package mips_pkg;

    localparam int unsigned OPC_W     = 6;
    localparam int unsigned MAX_REG_W = 8;

    localparam logic [OPC_W-1:0] ALUOP   = 6'b000000;
    localparam logic [OPC_W-1:0] JAL     = 6'b000011;
    localparam logic [OPC_W-1:0] ADD_IMM = 6'b001000;
    localparam logic [OPC_W-1:0] LW      = 6'b100011;

    // dst is sized for the widest supported register file; narrower cores zero-extend.
    typedef struct packed {
        logic                 v;
        logic [MAX_REG_W-1:0] dst;
    } pipe_entry_t;

endpackage

// File: rtl/dest_sel.sv
// Combinational opcode -> write-back destination select; 0 means "no write".
module dest_sel
    import mips_pkg::*;
#(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LINK_REG = 31
) (
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic [REG_W-1:0] rt_i,
    output logic [REG_W-1:0] dst_o
);

    always_comb begin
        dst_o = '0;
        if (opcode_i == ALUOP && rd_i != '0) begin
            dst_o = rd_i;
        end else if (opcode_i == ADD_IMM && rt_i != '0) begin
            dst_o = rt_i;
        end else if (opcode_i == LW && rt_i != '0) begin
            dst_o = rt_i;
        end else if (opcode_i == JAL) begin
            dst_o = REG_W'(LINK_REG);
        end
    end

endmodule

// File: rtl/dest_reg_tracker.sv
// Carries resolved destinations down a DEPTH-stage pipe to write-back and
// raises a RAW stall for the decode instruction; flush kills younger entries.
module dest_reg_tracker
    import mips_pkg::*;
#(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LINK_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [OPC_W-1:0] opcode,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rs_src,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic             flush,
    output logic             stall,
    output logic             wb_en,
    output logic [REG_W-1:0] wb_dst
);

    localparam int unsigned HAZ_N = DEPTH - 1;

    pipe_entry_t          stage_q [DEPTH];
    pipe_entry_t          stage_d [DEPTH];
    logic [REG_W-1:0]     dec_dst;
    logic [MAX_REG_W-1:0] rs_ext;
    logic [MAX_REG_W-1:0] rt_ext;
    logic [HAZ_N-1:0]     hit;

    dest_sel #(
        .REG_W    (REG_W),
        .LINK_REG (LINK_REG)
    ) u_dest_sel (
        .opcode_i (opcode),
        .rd_i     (rd),
        .rt_i     (rt),
        .dst_o    (dec_dst)
    );

    assign rs_ext = MAX_REG_W'(rs_src);
    assign rt_ext = MAX_REG_W'(rt);

    // The write-back stage is excluded: the register file writes before it reads.
    for (genvar g = 0; g < HAZ_N; g++) begin : g_haz
        assign hit[g] = stage_q[g].v && (stage_q[g].dst != '0) &&
                        ((rs_used && (rs_src != '0) && (stage_q[g].dst == rs_ext)) ||
                         (rt_used && (rt != '0) && (stage_q[g].dst == rt_ext)));
    end

    assign stall = valid_in & ~flush & (|hit);

    // Flush clears everything younger than the entry currently writing back.
    always_comb begin
        stage_d[0]     = '0;
        stage_d[0].v   = valid_in & ~stall & ~flush & (dec_dst != '0);
        stage_d[0].dst = stage_d[0].v ? MAX_REG_W'(dec_dst) : '0;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = flush ? '0 : stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign wb_en  = stage_q[DEPTH-1].v;
    assign wb_dst = stage_q[DEPTH-1].dst[REG_W-1:0];

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Scoreboard bench for dest_reg_tracker at DEPTH=3/REG_W=5 and DEPTH=5/REG_W=6.
module tb_dest_reg_tracker;
    import mips_pkg::*;

    localparam logic [5:0] SW_OP = 6'b101011;

    typedef struct {
        logic [5:0] dst;
        int         cyc;
    } wb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_in = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] rd = '0;
    logic [5:0] rt = '0;
    logic [5:0] rs_src = '0;
    logic       rs_used = 1'b0;
    logic       rt_used = 1'b0;
    logic       flush = 1'b0;
    logic       sel = 1'b0;
    logic       mon_en = 1'b0;

    logic       stall_a, wb_en_a;
    logic [4:0] wb_dst_a;
    logic       stall_b, wb_en_b;
    logic [5:0] wb_dst_b;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    wb_t qa[$];
    wb_t qb[$];
    wb_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dest_reg_tracker #(.REG_W(5), .DEPTH(3), .LINK_REG(31)) u_dut_a (
        .clk(clk), .reset(reset), .valid_in(valid_in & ~sel), .opcode(opcode),
        .rd(rd[4:0]), .rt(rt[4:0]), .rs_src(rs_src[4:0]), .rs_used(rs_used),
        .rt_used(rt_used), .flush(flush), .stall(stall_a), .wb_en(wb_en_a),
        .wb_dst(wb_dst_a)
    );

    dest_reg_tracker #(.REG_W(6), .DEPTH(5), .LINK_REG(63)) u_dut_b (
        .clk(clk), .reset(reset), .valid_in(valid_in & sel), .opcode(opcode),
        .rd(rd), .rt(rt), .rs_src(rs_src), .rs_used(rs_used),
        .rt_used(rt_used), .flush(flush), .stall(stall_b), .wb_en(wb_en_b),
        .wb_dst(wb_dst_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one instruction until accepted; expects exp_stalls stall cycles.
    task automatic issue(input logic [5:0] op, input logic [5:0] d, input logic [5:0] t,
                         input logic [5:0] s, input logic su, input logic tu,
                         input int exp_stalls, input logic [5:0] exp_dst);
        int  stalls = 0;
        bit  done = 0;
        logic st;
        opcode = op; rd = d; rt = t; rs_src = s; rs_used = su; rt_used = tu;
        valid_in = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            st = sel ? stall_b : stall_a;
            @(posedge clk); #1;
            if (st) stalls++;
            else done = 1;
        end
        valid_in = 1'b0;
        check("stall_cycles", done ? stalls : -1, exp_stalls);
        if (done && exp_dst != '0) begin
            if (sel) qb.push_back('{dst: exp_dst, cyc: cyc + 4});
            else     qa.push_back('{dst: exp_dst, cyc: cyc + 2});
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write-back monitors: every wb_en must match the oldest expected write and cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            while (qa.size() > 0 && qa[0].cyc < cyc) begin
                ea = qa.pop_front();
                check("wb_a_missing", -1, int'(ea.dst));
            end
            if (wb_en_a) begin
                if (qa.size() == 0) begin
                    check("wb_a_unexpected", int'(wb_dst_a), -1);
                end else begin
                    ea = qa.pop_front();
                    check("wb_a_dst", int'(wb_dst_a), int'(ea.dst));
                    check("wb_a_cycle", cyc, ea.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            while (qb.size() > 0 && qb[0].cyc < cyc) begin
                eb = qb.pop_front();
                check("wb_b_missing", -1, int'(eb.dst));
            end
            if (wb_en_b) begin
                if (qb.size() == 0) begin
                    check("wb_b_unexpected", int'(wb_dst_b), -1);
                end else begin
                    eb = qb.pop_front();
                    check("wb_b_dst", int'(wb_dst_b), int'(eb.dst));
                    check("wb_b_cycle", cyc, eb.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("rst_wb_en_a", int'(wb_en_a), 0);
        check("rst_wb_dst_a", int'(wb_dst_a), 0);
        check("rst_stall_a", int'(stall_a), 0);
        check("rst_wb_en_b", int'(wb_en_b), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Fill the pipe with r1..r3, then reset asynchronously mid-cycle
        opcode = ALUOP; rs_used = 1'b0; rt_used = 1'b0; rt = '0; rs_src = '0;
        for (int i = 1; i <= 3; i++) begin
            rd = 6'(i); valid_in = 1'b1;
            @(posedge clk); #1;
        end
        rd = 6'd9; rs_src = 6'd2; rs_used = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_rst_wb_en", int'(wb_en_a), 0);
        check("async_rst_wb_dst", int'(wb_dst_a), 0);
        check("async_rst_stall", int'(stall_a), 0);
        valid_in = 1'b0; rs_used = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_wb_en", int'(wb_en_a), 0);
        end
        idle(1);
        mon_en = 1'b1;

        // Destination select, back to back
        issue(ALUOP,   6'd7, 6'd3, 6'd0, 1'b0, 1'b0, 0, 6'd7);
        issue(ADD_IMM, 6'd5, 6'd9, 6'd0, 1'b0, 1'b0, 0, 6'd9);
        issue(LW,      6'd5, 6'd0, 6'd0, 1'b0, 1'b0, 0, 6'd0);
        issue(JAL,     6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 0, 6'd31);
        issue(SW_OP,   6'd6, 6'd5, 6'd0, 1'b0, 1'b0, 0, 6'd0);
        idle(4);

        // RAW on rs, on rt, and with one instruction of separation
        issue(ADD_IMM, 6'd0, 6'd4,  6'd0,  1'b0, 1'b0, 0, 6'd4);
        issue(ALUOP,   6'd5, 6'd0,  6'd4,  1'b1, 1'b0, 2, 6'd5);
        issue(LW,      6'd0, 6'd6,  6'd0,  1'b0, 1'b0, 0, 6'd6);
        issue(ALUOP,   6'd8, 6'd6,  6'd0,  1'b0, 1'b1, 2, 6'd8);
        issue(ADD_IMM, 6'd0, 6'd14, 6'd0,  1'b0, 1'b0, 0, 6'd14);
        issue(ADD_IMM, 6'd0, 6'd15, 6'd0,  1'b0, 1'b0, 0, 6'd15);
        issue(ALUOP,   6'd16, 6'd0, 6'd14, 1'b1, 1'b0, 1, 6'd16);
        // Unlisted opcode still has its sources checked
        issue(ADD_IMM, 6'd0, 6'd13, 6'd0,  1'b0, 1'b0, 0, 6'd13);
        issue(SW_OP,   6'd0, 6'd2,  6'd13, 1'b1, 1'b0, 2, 6'd0);
        idle(4);

        // No false stall on r0 or on an unused source
        issue(ALUOP,   6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 0, 6'd0);
        issue(ALUOP,   6'd10, 6'd0,  6'd0,  1'b1, 1'b0, 0, 6'd10);
        issue(ADD_IMM, 6'd0,  6'd11, 6'd0,  1'b0, 1'b0, 0, 6'd11);
        issue(ALUOP,   6'd12, 6'd0,  6'd11, 1'b0, 1'b0, 0, 6'd12);
        idle(4);

        // Flush while r1 writes back: r2, r3 and the flushed decode are dropped
        issue(ALUOP, 6'd1, 6'd0, 6'd0, 1'b0, 1'b0, 0, 6'd1);
        issue(ALUOP, 6'd2, 6'd0, 6'd0, 1'b0, 1'b0, 0, 6'd0);
        issue(ALUOP, 6'd3, 6'd0, 6'd0, 1'b0, 1'b0, 0, 6'd0);
        opcode = ALUOP; rd = 6'd12; rs_src = 6'd2; rs_used = 1'b1; rt_used = 1'b0;
        valid_in = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_stall", int'(stall_a), 0);
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        issue(ALUOP, 6'd17, 6'd0, 6'd3, 1'b1, 1'b0, 0, 6'd17);
        idle(5);

        // Deeper, wider configuration
        sel = 1'b1;
        issue(JAL,   6'd0,  6'd0, 6'd0,  1'b0, 1'b0, 0, 6'd63);
        issue(ALUOP, 6'd20, 6'd0, 6'd63, 1'b1, 1'b0, 4, 6'd20);
        issue(ALUOP, 6'd40, 6'd0, 6'd0,  1'b0, 1'b0, 0, 6'd40);
        idle(8);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
